// File: rtl/wrptr_full_gray_af_if.sv
// Write-side bundle between the write client / pointer logic and the flag consumers.
// The handshake: a write transfers in every i_wr_clk cycle where i_wr_en=1 and o_full=0 (o_wr_accept=1); i_wr_en never waits on o_wr_accept.
interface wrptr_full_gray_af_if #(
    parameter int PTR_WIDTH = 3
);
    logic                 i_wr_en;
    logic [PTR_WIDTH:0]   i_rdptr_gray_sync;
    logic [PTR_WIDTH:0]   i_af_thresh;
    logic                 i_clr_ovf;
    logic                 o_wr_accept;
    logic [PTR_WIDTH-1:0] o_wraddr;
    logic [PTR_WIDTH:0]   o_wrptr_bin;
    logic [PTR_WIDTH:0]   o_wrptr_gray;
    logic                 o_full;
    logic                 o_almost_full;
    logic [PTR_WIDTH:0]   o_wr_level;
    logic                 o_overflow;

    modport master (
        output i_wr_en, i_rdptr_gray_sync, i_af_thresh, i_clr_ovf,
        input  o_wr_accept, o_wraddr, o_wrptr_bin, o_wrptr_gray,
               o_full, o_almost_full, o_wr_level, o_overflow
    );

    modport slave (
        input  i_wr_en, i_rdptr_gray_sync, i_af_thresh, i_clr_ovf,
        output o_wr_accept, o_wraddr, o_wrptr_bin, o_wrptr_gray,
               o_full, o_almost_full, o_wr_level, o_overflow
    );
endinterface

// File: rtl/wrptr_full_gray_af.sv
// Async-FIFO write pointer: binary + Gray pointer, registered full / level / almost-full / overflow.
// Define WRPTR_OVF_STICKY_EN to make o_overflow sticky (cleared by i_clr_ovf); default is a one-cycle pulse.
module wrptr_full_gray_af #(
    parameter int PTR_WIDTH = 3
) (
    input  logic                  i_wr_clk,
    input  logic                  i_rst_n,
    wrptr_full_gray_af_if.slave   bus
);
    logic [PTR_WIDTH:0] wbin_q;
    logic [PTR_WIDTH:0] wgray_q;
    logic [PTR_WIDTH:0] level_q;
    logic               full_q;
    logic               af_q;
    logic               ovf_q;

    logic               wr_accept;
    logic [PTR_WIDTH:0] wbin_next;
    logic [PTR_WIDTH:0] wgray_next;
    logic [PTR_WIDTH:0] rg;
    logic [PTR_WIDTH:0] rbin;
    logic [PTR_WIDTH:0] full_cmp;
    logic [PTR_WIDTH:0] level_next;
    logic               full_next;
    logic               af_next;
    logic               ovf_evt;
    logic               ovf_next;

    always_comb begin
        wr_accept  = bus.i_wr_en & ~full_q;
        wbin_next  = wbin_q + {{PTR_WIDTH{1'b0}}, wr_accept};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rg         = bus.i_rdptr_gray_sync;
        rbin       = '0;
        // Each binary bit is the XOR of all Gray bits at and above it.
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            rbin[i] = ^(rg >> i);
        end
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        full_cmp   = {~rg[PTR_WIDTH:PTR_WIDTH-1], rg[PTR_WIDTH-2:0]};
        full_next  = (wgray_next == full_cmp);
        level_next = wbin_next - rbin;
        af_next    = (level_next >= bus.i_af_thresh);
        ovf_evt    = bus.i_wr_en & full_q;
`ifdef WRPTR_OVF_STICKY_EN
        ovf_next   = ovf_evt | (ovf_q & ~bus.i_clr_ovf);
`else
        ovf_next   = ovf_evt;
`endif
    end

    always_ff @(posedge i_wr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_next;
            wgray_q <= wgray_next;
            level_q <= level_next;
            full_q  <= full_next;
            af_q    <= af_next;
            ovf_q   <= ovf_next;
        end
    end

    assign bus.o_wr_accept   = wr_accept;
    assign bus.o_wraddr      = wbin_q[PTR_WIDTH-1:0];
    assign bus.o_wrptr_bin   = wbin_q;
    assign bus.o_wrptr_gray  = wgray_q;
    assign bus.o_full        = full_q;
    assign bus.o_almost_full = af_q;
    assign bus.o_wr_level    = level_q;
    assign bus.o_overflow    = ovf_q;
endmodule

// File: tb/tb_wrptr_full_gray_af.sv
// Directed bench for wrptr_full_gray_af at PTR_WIDTH=3: vector table plus wrap and mid-cycle reset sequences.
module tb_wrptr_full_gray_af;
  localparam int PW = 3;

  logic i_wr_clk = 1'b0;
  logic i_rst_n  = 1'b0;
  int   total = 0;
  int   bad   = 0;

  wrptr_full_gray_af_if #(.PTR_WIDTH(PW)) bus ();

  wrptr_full_gray_af #(.PTR_WIDTH(PW)) dut (
    .i_wr_clk (i_wr_clk),
    .i_rst_n  (i_rst_n),
    .bus      (bus)
  );

  // clock / reset
  always #5 i_wr_clk = ~i_wr_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         rst;
    bit         wr;
    bit         clr;
    logic [3:0] rg;
    logic [3:0] th;
    bit         acc;
    logic [3:0] bin;
    bit         full;
    bit         af;
    logic [3:0] lvl;
    bit         ost;
    bit         opl;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  function automatic logic [3:0] g(logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge i_wr_clk);
    #1;
  endtask

  task automatic drive(bit wr, bit clr, logic [3:0] rg, logic [3:0] th);
    bus.i_wr_en           = wr;
    bus.i_clr_ovf         = clr;
    bus.i_rdptr_gray_sync = rg;
    bus.i_af_thresh       = th;
  endtask

  task automatic add(bit rst, bit wr, bit clr, logic [3:0] rg, logic [3:0] th, bit acc,
                     logic [3:0] bin, bit full, bit af, logic [3:0] lvl, bit ost, bit opl);
    vec_t v;
    v.rst = rst; v.wr = wr; v.clr = clr; v.rg = rg; v.th = th; v.acc = acc;
    v.bin = bin; v.full = full; v.af = af; v.lvl = lvl; v.ost = ost; v.opl = opl;
    vecs.push_back(v);
  endtask

  task automatic check_regs(string tag, logic [3:0] bin, bit full, bit af, logic [3:0] lvl, bit ovf);
    chk({tag, ".bin"},   bus.o_wrptr_bin,   bin);
    chk({tag, ".gray"},  bus.o_wrptr_gray,  g(bin));
    chk({tag, ".addr"},  bus.o_wraddr,      bin[2:0]);
    chk({tag, ".full"},  bus.o_full,        full);
    chk({tag, ".af"},    bus.o_almost_full, af);
    chk({tag, ".level"}, bus.o_wr_level,    lvl);
    chk({tag, ".ovf"},   bus.o_overflow,    ovf);
  endtask

  task automatic run_vecs();
    bit ovf_exp;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) i_rst_n = 1'b0;
      drive(vecs[i].wr, vecs[i].clr, vecs[i].rg, vecs[i].th);
      #1;
      chk($sformatf("v%0d.accept", i), bus.o_wr_accept, vecs[i].acc);
      tick();
      if (vecs[i].rst) i_rst_n = 1'b1;
`ifdef WRPTR_OVF_STICKY_EN
      ovf_exp = vecs[i].ost;
`else
      ovf_exp = vecs[i].opl;
`endif
      check_regs($sformatf("v%0d", i), vecs[i].bin, vecs[i].full, vecs[i].af, vecs[i].lvl, ovf_exp);
    end
  endtask

  initial begin
    logic [3:0] wb;
    logic [3:0] rb;
    logic [3:0] prev_gray;
    int         wraps;

    drive(1'b0, 1'b0, 4'd0, 4'd8);
    #2;

    // Fill to full with read pointer at 0, then overflow behaviour and delayed full release.
    add(1, 0, 0, 4'd0, 4'd8, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    add(0, 0, 0, 4'd0, 4'd8, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 0, 4'd0, 4'd8, 1, 4'(k), k == 8, k == 8, 4'(k), 0, 0);
    add(0, 1, 0, 4'd0, 4'd8, 0, 4'd8, 1, 1, 4'd8, 1, 1);
    add(0, 1, 0, 4'd0, 4'd8, 0, 4'd8, 1, 1, 4'd8, 1, 1);
    add(0, 0, 0, 4'd0, 4'd8, 0, 4'd8, 1, 1, 4'd8, 1, 0);
    add(0, 0, 1, 4'd0, 4'd8, 0, 4'd8, 1, 1, 4'd8, 0, 0);
    add(0, 1, 1, 4'd0, 4'd8, 0, 4'd8, 1, 1, 4'd8, 1, 1);
    add(0, 0, 1, 4'd0, 4'd8, 0, 4'd8, 1, 1, 4'd8, 0, 0);
    add(0, 1, 0, 4'd1, 4'd8, 0, 4'd8, 0, 0, 4'd7, 1, 1);
    add(0, 1, 0, 4'd1, 4'd8, 1, 4'd9, 1, 1, 4'd8, 1, 0);
    add(0, 0, 1, 4'd1, 4'd8, 0, 4'd9, 1, 1, 4'd8, 0, 0);

    // Almost-full at threshold 6, reader advance, threshold 0 and above depth.
    add(1, 0, 0, 4'd0, 4'd6, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    for (int k = 1; k <= 6; k++)
      add(0, 1, 0, 4'd0, 4'd6, 1, 4'(k), 0, k >= 6, 4'(k), 0, 0);
    add(0, 0, 0, 4'd1, 4'd6, 0, 4'd6, 0, 0, 4'd5, 0, 0);
    add(0, 0, 0, 4'd1, 4'd0, 0, 4'd6, 0, 1, 4'd5, 0, 0);
    add(0, 0, 0, 4'd1, 4'd9, 0, 4'd6, 0, 0, 4'd5, 0, 0);
    add(0, 1, 0, 4'd1, 4'd9, 1, 4'd7, 0, 0, 4'd6, 0, 0);
    add(0, 1, 0, 4'd1, 4'd9, 1, 4'd8, 0, 0, 4'd7, 0, 0);
    add(0, 1, 0, 4'd1, 4'd9, 1, 4'd9, 1, 0, 4'd8, 0, 0);
    add(0, 1, 0, 4'd1, 4'd9, 0, 4'd9, 1, 0, 4'd8, 1, 1);

    run_vecs();

    // Wrap: 20 writes with a reader two entries behind.
    i_rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd9);
    tick();
    i_rst_n   = 1'b1;
    wb        = 4'd0;
    prev_gray = 4'd0;
    wraps     = 0;
    for (int k = 0; k < 20; k++) begin
      rb = (k >= 2) ? 4'(wb - 4'd2) : 4'd0;
      drive(1'b1, 1'b0, g(rb), 4'd9);
      #1;
      chk("wrap.accept", bus.o_wr_accept, 1'b1);
      wb = wb + 4'd1;
      exp_q.push_back(g(wb));
      tick();
      chk("wrap.gray", bus.o_wrptr_gray, exp_q.pop_front());
      chk("wrap.bin", bus.o_wrptr_bin, wb);
      chk("wrap.level", bus.o_wr_level, 4'(wb - rb));
      chk("wrap.full", bus.o_full, 1'b0);
      chk("wrap.onebit", $countones(bus.o_wrptr_gray ^ prev_gray), 1);
      if (prev_gray == 4'b1000 && bus.o_wrptr_gray == 4'b0000) wraps++;
      prev_gray = bus.o_wrptr_gray;
    end
    chk("wrap.count", wraps, 1);

    // Mid-cycle asynchronous reset with the pointer at 5.
    i_rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd6);
    tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 4'd0, 4'd6);
      tick();
    end
    chk("mid.pre_bin", bus.o_wrptr_bin, 4'd5);
    drive(1'b0, 1'b0, 4'd0, 4'd6);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("mid.accept", bus.o_wr_accept, 1'b0);
    check_regs("mid", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    i_rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'd0, 4'd6);
    #1;
    chk("mid.first_accept", bus.o_wr_accept, 1'b1);
    chk("mid.first_addr", bus.o_wraddr, 3'd0);
    tick();
    check_regs("mid.after", 4'd1, 1'b0, 1'b0, 4'd1, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
